// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: load funct3 codes, writeback source
// select codes and the MEM/WB pipeline register layout.
package rv32i_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic [2:0]  funct3;
    logic [1:0]  wb_sel;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data aligner: picks the byte/halfword/word lane addressed by the low
// address bits, extends it per funct3, and flags misaligned or reserved codes.
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend the selected lane; misaligned and reserved codes return zero.
  always_comb begin
    data_o       = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {24'b0, byte_sel};
      F3_LH: begin
        if (off_i[0]) misaligned_o = 1'b1;
        else          data_o = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off_i[0]) misaligned_o = 1'b1;
        else          data_o = {16'b0, half_sel};
      end
      F3_LW: begin
        if (off_i != 2'b00) misaligned_o = 1'b1;
        else                data_o = rdata_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux, register-file write port,
// load fault flags and a retired-instruction counter.
module mem_wb_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_alu_result_i,
  input  logic [31:0]      mem_pc_plus4_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [1:0]       mem_wb_sel_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_misaligned_o,
  output logic             wb_illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  mem_wb_t          wb_q, wb_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [31:0] load_data;
  logic        load_mis;
  logic        load_ill;
  logic        is_load;
  logic        retire;

  // Next register value: flush kills valid only, stall holds, else capture.
  always_comb begin
    wb_d = wb_q;
    if (flush_i) begin
      wb_d.valid = 1'b0;
    end else if (!stall_i) begin
      wb_d.valid      = mem_valid_i;
      wb_d.alu_result = mem_alu_result_i;
      wb_d.pc_plus4   = mem_pc_plus4_i;
      wb_d.rdata      = mem_rdata_i;
      wb_d.rd         = mem_rd_i;
      wb_d.reg_write  = mem_reg_write_i;
      wb_d.funct3     = mem_funct3_i;
      wb_d.wb_sel     = mem_wb_sel_i;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  load_align u_load_align (
    .rdata_i      (wb_q.rdata),
    .off_i        (wb_q.alu_result[1:0]),
    .funct3_i     (wb_q.funct3),
    .data_o       (load_data),
    .misaligned_o (load_mis),
    .illegal_o    (load_ill)
  );

  // Writeback mux, fault flags and register-file write enable.
  always_comb begin
    is_load         = (wb_q.wb_sel == WB_SEL_MEM);
    wb_valid_o      = wb_q.valid;
    wb_rd_o         = wb_q.rd;
    wb_misaligned_o = wb_q.valid & is_load & load_mis;
    wb_illegal_o    = wb_q.valid & is_load & load_ill;
    case (wb_q.wb_sel)
      WB_SEL_MEM: wb_data_o = load_data;
      WB_SEL_PC4: wb_data_o = wb_q.pc_plus4;
      default:    wb_data_o = wb_q.alu_result;
    endcase
    wb_we_o = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0)
            & ~wb_misaligned_o & ~wb_illegal_o;
  end

  // Retirement: flush does not block the instruction already in WB.
  always_comb begin
    retire    = wb_q.valid & ~stall_i & ~wb_misaligned_o & ~wb_illegal_o;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by
// randomized traffic, compared against a transaction-level model.
module tb_mem_wb_stage;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  f3;
    logic [1:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, mem_valid_i;
  logic [31:0] mem_alu_result_i, mem_pc_plus4_i, mem_rdata_i;
  logic [4:0]  mem_rd_i;
  logic        mem_reg_write_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_wb_sel_i;

  logic        wb_valid_o, wb_we_o, wb_misaligned_o, wb_illegal_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [63:0] instret_o;

  logic        s_valid, s_we, s_mis, s_ill;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic [3:0]  s_instret;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_alu_result_i(mem_alu_result_i),
    .mem_pc_plus4_i(mem_pc_plus4_i), .mem_rdata_i(mem_rdata_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_funct3_i(mem_funct3_i), .mem_wb_sel_i(mem_wb_sel_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
    .wb_data_o(wb_data_o), .wb_misaligned_o(wb_misaligned_o),
    .wb_illegal_o(wb_illegal_o), .instret_o(instret_o)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_alu_result_i(mem_alu_result_i),
    .mem_pc_plus4_i(mem_pc_plus4_i), .mem_rdata_i(mem_rdata_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_funct3_i(mem_funct3_i), .mem_wb_sel_i(mem_wb_sel_i),
    .wb_valid_o(s_valid), .wb_rd_o(s_rd), .wb_we_o(s_we),
    .wb_data_o(s_data), .wb_misaligned_o(s_mis),
    .wb_illegal_o(s_ill), .instret_o(s_instret)
  );

  int total = 0;
  int passed = 0;

  // Reference model state: the instruction in WB and the retired count.
  txn_t            m;
  bit              m_valid;
  bit              m_fields_ok;
  longint unsigned m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Load result from the architectural rules: access size, alignment, extension.
  task automatic ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                          input logic [2:0] f3, output logic [31:0] data,
                          output bit mis, output bit ill);
    longint size, off, val, lim;
    data = 32'h0;
    mis  = 0;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (!ill) begin
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off  = longint'(addr % 4);
      mis  = (off % size) != 0;
      if (!mis) begin
        lim = longint'(1) << (8 * size);
        val = (longint'(rdata) >> (8 * off)) % lim;
        if (!f3[2] && val >= lim / 2) val = val - lim;
        data = 32'(val);
      end
    end
  endtask

  task automatic ref_out(output logic [31:0] data, output bit mis,
                         output bit ill, output bit we);
    logic [31:0] ld;
    bit lmis, lill, is_load;
    ref_load(m.rdata, m.alu, m.f3, ld, lmis, lill);
    is_load = (m.sel == 2'b01);
    mis  = m_valid && is_load && lmis;
    ill  = m_valid && is_load && lill;
    data = (m.sel == 2'b01) ? ld : (m.sel == 2'b10) ? m.pc4 : m.alu;
    we   = m_valid && m.rw && (m.rd != 5'd0) && !mis && !ill;
  endtask

  task automatic model_reset();
    m = '{valid: 1'b0, alu: 32'h0, pc4: 32'h0, rdata: 32'h0,
          rd: 5'h0, rw: 1'b0, f3: 3'h0, sel: 2'h0};
    m_valid     = 0;
    m_fields_ok = 1;
    m_cnt       = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ed;
    bit emis, eill, ewe;
    ref_out(ed, emis, eill, ewe);
    chk({tag, ".valid"},   {63'h0, wb_valid_o},      {63'h0, m_valid});
    chk({tag, ".we"},      {63'h0, wb_we_o},         {63'h0, ewe});
    chk({tag, ".mis"},     {63'h0, wb_misaligned_o}, {63'h0, emis});
    chk({tag, ".ill"},     {63'h0, wb_illegal_o},    {63'h0, eill});
    chk({tag, ".instret"}, instret_o,                m_cnt);
    chk({tag, ".instret4"}, {60'h0, s_instret},      m_cnt % 16);
    if (m_fields_ok) begin
      chk({tag, ".rd"},   {59'h0, wb_rd_o},   {59'h0, m.rd});
      chk({tag, ".data"}, {32'h0, wb_data_o}, {32'h0, ed});
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check.
  task automatic step(input string tag, input bit st, input bit fl, input txn_t t);
    logic [31:0] ed;
    bit emis, eill, ewe;
    stall_i          = st;
    flush_i          = fl;
    mem_valid_i      = t.valid;
    mem_alu_result_i = t.alu;
    mem_pc_plus4_i   = t.pc4;
    mem_rdata_i      = t.rdata;
    mem_rd_i         = t.rd;
    mem_reg_write_i  = t.rw;
    mem_funct3_i     = t.f3;
    mem_wb_sel_i     = t.sel;
    @(posedge clk);
    ref_out(ed, emis, eill, ewe);
    if (m_valid && !st && !emis && !eill) m_cnt++;
    if (fl) begin
      m_valid     = 0;
      m_fields_ok = 0;
    end else if (!st) begin
      m           = t;
      m_valid     = t.valid;
      m_fields_ok = 1;
    end
    #1;
    check_all(tag);
  endtask

  function automatic txn_t mk(input logic v, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input logic rw, input logic [2:0] f3, input logic [1:0] sel);
    txn_t t;
    t.valid = v; t.alu = alu; t.pc4 = pc4; t.rdata = rdata;
    t.rd = rd; t.rw = rw; t.f3 = f3; t.sel = sel;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t.valid = ($urandom_range(0, 3) != 0);
    t.alu   = $urandom;
    t.pc4   = $urandom;
    t.rdata = $urandom;
    t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    t.rw    = 1'($urandom);
    t.f3    = 3'($urandom);
    t.sel   = 2'($urandom);
    return t;
  endfunction

  txn_t bubble;

  initial begin
    bubble = mk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 2'd0);
    reset = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0;
    mem_alu_result_i = '0; mem_pc_plus4_i = '0; mem_rdata_i = '0;
    mem_rd_i = '0; mem_reg_write_i = 1'b0; mem_funct3_i = '0; mem_wb_sel_i = '0;
    model_reset();
    #3;
    check_all("reset");
    chk("reset.data0", {32'h0, wb_data_o}, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // LB from byte 3, sign-extended, then retirement on the next edge.
    step("lb", 0, 0, mk(1, 32'h103, 32'h0, 32'h80FF_1234, 5'd5, 1, 3'b000, 2'b01));
    chk("lb.const_data", {32'h0, wb_data_o}, 64'hFFFF_FF80);
    chk("lb.const_rd",   {59'h0, wb_rd_o},   64'd5);
    chk("lb.const_we",   {63'h0, wb_we_o},   64'd1);
    step("lb_retire", 0, 0, mk(1, 32'h102, 32'h0, 32'hBEEF_0000, 5'd6, 1, 3'b101, 2'b01));
    chk("lb.retired", instret_o, 64'd1);
    chk("lhu.const_data", {32'h0, wb_data_o}, 64'h0000_BEEF);
    step("lh_mis", 0, 0, mk(1, 32'h101, 32'h0, 32'hBEEF_0000, 5'd7, 1, 3'b001, 2'b01));
    chk("lh.const_mis", {63'h0, wb_misaligned_o}, 64'd1);
    chk("lh.const_we",  {63'h0, wb_we_o},         64'd0);
    step("pc4", 0, 0, mk(1, 32'hDEAD_0000, 32'h44, 32'h0, 5'd1, 1, 3'b000, 2'b10));
    chk("lh.not_retired", instret_o, 64'd2);
    chk("pc4.const_data", {32'h0, wb_data_o}, 64'h44);
    step("pc4_x0", 0, 0, mk(1, 32'hDEAD_0000, 32'h44, 32'h0, 5'd0, 1, 3'b000, 2'b10));
    chk("x0.const_we", {63'h0, wb_we_o}, 64'd0);
    step("lw_ill", 0, 0, mk(1, 32'h200, 32'h0, 32'h1234_5678, 5'd9, 1, 3'b011, 2'b01));
    chk("ill.const_flag", {63'h0, wb_illegal_o}, 64'd1);

    // Stall with an ALU op held in WB, then release.
    step("alu", 0, 0, mk(1, 32'h1234, 32'h0, 32'h0, 5'd3, 1, 3'b000, 2'b00));
    for (int unsigned i = 0; i < 3; i++)
      step("stall", 1, 0, mk(1, 32'h9999, 32'h0, 32'h0, 5'd4, 1, 3'b000, 2'b00));
    chk("stall.const_data", {32'h0, wb_data_o}, 64'h1234);
    step("release", 0, 0, bubble);

    // Flush wins over stall.
    step("pre_flush", 0, 0, mk(1, 32'h55, 32'h0, 32'h0, 5'd8, 1, 3'b000, 2'b00));
    step("flush_stall", 1, 1, mk(1, 32'h66, 32'h0, 32'h0, 5'd8, 1, 3'b000, 2'b00));
    chk("flush.const_valid", {63'h0, wb_valid_o}, 64'd0);

    // Asynchronous reset mid-cycle with a valid instruction in WB.
    step("pre_reset", 0, 0, mk(1, 32'h77, 32'h0, 32'h0, 5'd10, 1, 3'b000, 2'b00));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // 16 retirements wrap the 4-bit counter to zero.
    for (int unsigned i = 0; i < 17; i++)
      step("wrap", 0, 0, mk(1, 32'(i), 32'h0, 32'h0, 5'd2, 1, 3'b000, 2'b00));
    chk("wrap.const4",  {60'h0, s_instret}, 64'd0);
    chk("wrap.const64", instret_o, 64'd16);

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), rnd());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
